// File: rtl/matdet_stream_loader_if.sv
// Stream bundle for matdet_stream_loader: element input stream and determinant result stream.
// With MATDET_STREAM_LOADER_LASTCHK_EN defined, adds in_last framing and the err_sticky flag.
interface matdet_stream_loader_if #(
  parameter int DATA_WIDTH = 8
);
  // valid/ready: a beat transfers on a rising edge where valid && ready; the source
  // holds valid and data stable until then, and ready never depends on valid.
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_det;
`ifdef MATDET_STREAM_LOADER_LASTCHK_EN
  logic                  in_last;
  logic                  err_sticky;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef MATDET_STREAM_LOADER_LASTCHK_EN
    input  in_last,
    output err_sticky,
`endif
    output in_ready, out_valid, out_det
  );

  modport master (
    output in_valid, in_data, out_ready,
`ifdef MATDET_STREAM_LOADER_LASTCHK_EN
    output in_last,
    input  err_sticky,
`endif
    input  in_ready, out_valid, out_det
  );
endinterface

// File: rtl/matdet_stream_loader.sv
// Streams N*N elements into a flat row-major bus for a combinational determinant stage,
// waits SETTLE_CYCLES, captures det_i and returns it on a valid/ready handshake.
// Optional in_last framing check: MATDET_STREAM_LOADER_LASTCHK_EN.
module matdet_stream_loader #(
  parameter int DATA_WIDTH    = 8,
  parameter int N             = 11,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  matdet_stream_loader_if.slave          bus,
  output logic [N*N*DATA_WIDTH-1:0]      mat_o,
  input  logic [DATA_WIDTH-1:0]          det_i,
  output logic                           busy,
  output logic [1:0]                     state_o
);
  localparam int MATRIX_SIZE = N * N;
  localparam int CNT_W       = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam int SETTLE_W    = 8;
  localparam logic [CNT_W-1:0]    LAST_IDX   = CNT_W'(MATRIX_SIZE - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SETTLE = 2'd1,
    S_OUTPUT = 2'd2
  } state_e;

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [SETTLE_W-1:0]       settle_q;
  logic [N*N*DATA_WIDTH-1:0] mat_q;
  logic [DATA_WIDTH-1:0]     det_q;
  logic                      in_ready_q;
  logic                      out_valid_q;

  logic in_fire_d;
  logic is_last_d;
  logic frame_err_d;

  assign in_fire_d = bus.in_valid && in_ready_q;
  assign is_last_d = (cnt_q == LAST_IDX);

`ifdef MATDET_STREAM_LOADER_LASTCHK_EN
  logic err_q;

  // in_last must coincide exactly with the final element of the matrix.
  assign frame_err_d = in_fire_d && (bus.in_last != is_last_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (frame_err_d) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_sticky = err_q;
`else
  assign frame_err_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      settle_q    <= '0;
      mat_q       <= '0;
      det_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          in_ready_q <= 1'b1;
          if (in_fire_d) begin
            if (frame_err_d) begin
              // Misframed beat is swallowed and the partial matrix abandoned.
              cnt_q <= '0;
            end else begin
              mat_q[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
              if (is_last_d) begin
                cnt_q      <= '0;
                settle_q   <= SETTLE_VAL;
                in_ready_q <= 1'b0;
                state_q    <= S_SETTLE;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
        end
        S_SETTLE: begin
          settle_q <= settle_q - 1'b1;
          if (settle_q == SETTLE_W'(1)) begin
            det_q       <= det_i;
            out_valid_q <= 1'b1;
            state_q     <= S_OUTPUT;
          end
        end
        S_OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_LOAD;
          end
        end
        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_det   = det_q;
  assign mat_o         = mat_q;
  assign busy          = !((state_q == S_LOAD) && (cnt_q == '0));
  assign state_o       = state_q;
endmodule

// File: tb/tb_matdet_stream_loader.sv
// Directed bench for matdet_stream_loader (N=11, 8-bit, SETTLE_CYCLES=2) with a
// triangular-matrix stand-in for the determinant stage.
module tb_matdet_stream_loader;
  localparam int DW  = 8;
  localparam int N   = 11;
  localparam int MS  = N * N;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [MS*DW-1:0] mat;
  logic [DW-1:0]   det_model;
  logic            busy;
  logic [1:0]      state;
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  int              last_hs_cyc = 0;

  matdet_stream_loader_if #(.DATA_WIDTH(DW)) bus ();

  matdet_stream_loader #(
    .DATA_WIDTH(DW), .N(N), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .mat_o(mat),
    .det_i(det_model), .busy(busy), .state_o(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Determinant of a triangular matrix is the product of its diagonal (mod 256).
  always_comb begin
    det_model = 8'd1;
    for (int i = 0; i < N; i++) det_model = det_model * mat[i*(N+1)*DW +: DW];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] d0;
    logic [7:0] dr;
    logic [7:0] up;
    logic [7:0] exp_det;
    int         stall;
    bit         bub;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] elem(input vec_t v, input int k);
    int r, c;
    r = k / N;
    c = k % N;
    if (r == c) return (r == 0) ? v.d0 : v.dr;
    if (c > r) return v.up;
    return 8'd0;
  endfunction

  // Offers one beat at a negedge; returns the cycle number of the accepting edge.
  task automatic put_beat(input logic [7:0] d, input logic last, output int acc_cyc);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
`ifdef MATDET_STREAM_LOADER_LASTCHK_EN
    bus.in_last  = last;
`else
    if (last) t = 0;
`endif
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_vector(input vec_t v, input bit chk_b2b);
    int acc, lat;
    bus.out_ready = (v.stall == 0);
    for (int k = 0; k < MS; k++) begin
      if (v.bub && k > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      put_beat(elem(v, k), k == MS - 1, acc);
      if (k == 0 && chk_b2b) check("b2b_first_beat_cycle", acc, last_hs_cyc + 1);
    end
    check("mat_elem0", mat[7:0], v.d0);
    check("mat_elem120", mat[967:960], v.dr);
    check("mat_elem1", mat[15:8], v.up);
    check("mat_elem11", mat[95:88], 8'd0);
    check("in_ready_settle", bus.in_ready, 1'b0);
    // Cycles counted from the cycle in which the final beat is offered.
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 3);
    check("out_det", bus.out_det, v.exp_det);
    for (int s = 0; s < v.stall; s++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", bus.out_valid, 1'b1);
      check("stall_out_det", bus.out_det, v.exp_det);
      check("stall_in_ready", bus.in_ready, 1'b0);
    end
    if (v.stall > 0) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    last_hs_cyc = cyc;
    check("post_hs_out_valid", bus.out_valid, 1'b0);
    check("post_hs_in_ready", bus.in_ready, 1'b1);
    check("post_hs_busy", busy, 1'b0);
  endtask

  initial begin
    int acc;
    vec_t v;
    vecs[0] = '{d0: 8'd1,   dr: 8'd1,   up: 8'h00, exp_det: 8'd1,   stall: 0,  bub: 1'b0};
    vecs[1] = '{d0: 8'd1,   dr: 8'd1,   up: 8'h00, exp_det: 8'd1,   stall: 20, bub: 1'b1};
    vecs[2] = '{d0: 8'd2,   dr: 8'd2,   up: 8'h00, exp_det: 8'd0,   stall: 0,  bub: 1'b0};
    vecs[3] = '{d0: 8'd3,   dr: 8'd1,   up: 8'h00, exp_det: 8'd3,   stall: 0,  bub: 1'b0};
    vecs[4] = '{d0: 8'd1,   dr: 8'd1,   up: 8'h5A, exp_det: 8'd1,   stall: 0,  bub: 1'b1};
    vecs[5] = '{d0: 8'd5,   dr: 8'd3,   up: 8'h07, exp_det: 8'd77,  stall: 3,  bub: 1'b1};
    vecs[6] = '{d0: 8'hFF,  dr: 8'hFF,  up: 8'h00, exp_det: 8'hFF,  stall: 0,  bub: 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef MATDET_STREAM_LOADER_LASTCHK_EN
    bus.in_last   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_det", bus.out_det, 8'd0);
    check("rst_mat_zero", (mat == '0), 1'b1);
    check("rst_state", state, 2'd0);
`ifdef MATDET_STREAM_LOADER_LASTCHK_EN
    check("rst_err_sticky", bus.err_sticky, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", bus.in_ready, 1'b1);

    for (int i = 0; i < 7; i++) run_vector(vecs[i], i > 0);

    // Reset partway through a matrix: partial data and state are discarded.
    v = vecs[2];
    for (int k = 0; k < 60; k++) begin
      put_beat(elem(v, k), 1'b0, acc);
      if (k == 0) check("busy_loading", busy, 1'b1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_in_ready", bus.in_ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_mat_zero", (mat == '0), 1'b1);
    check("midrst_state", state, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("midrst_no_out_valid", bus.out_valid, 1'b0);
    end
    run_vector(vecs[0], 1'b0);

`ifdef MATDET_STREAM_LOADER_LASTCHK_EN
    // Early in_last on beat 50 drops the matrix and latches the sticky error.
    for (int k = 0; k <= 50; k++) put_beat(elem(vecs[0], k), k == 50, acc);
    check("lastchk_err_sticky", bus.err_sticky, 1'b1);
    check("lastchk_busy", busy, 1'b0);
    check("lastchk_in_ready", bus.in_ready, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("lastchk_no_out_valid", bus.out_valid, 1'b0);
    end
    run_vector(vecs[0], 1'b0);
    check("lastchk_err_held", bus.err_sticky, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
